mdsa_sort_arbiter: RTL and testbench
====================================

MDSA_SORT_ARBITER -- requirements
Module: mdsa_sort_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters sharing one sorter (legal 2..8).
REQ-002 SHALL have parameter TIMEOUT, default 127, maximum RUN cycles before the job is aborted (legal 8..255).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req  input  NREQ  per-requester sort request, level, held until done.
REQ-006 SHALL have port hold  input  1  pause request; freezes the sorter and the watchdog.
REQ-007 SHALL have port sort_ready  input  1  sorter idle/ready indication.
REQ-008 SHALL have port sort_oe  input  1  sorter output-valid pulse.
REQ-009 SHALL have port gnt  output  NREQ  one-hot grant, held for the whole job.
REQ-010 SHALL have port cur_id  output  3  index of the granted requester (data-mux select).
REQ-011 SHALL have port done  output  NREQ  one-cycle completion pulse to the granted requester.
REQ-012 SHALL have port sort_start  output  1  one-cycle START pulse to the sorter.
REQ-013 SHALL have port sort_en  output  1  sorter enable.
REQ-014 SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-015 SHALL have port err  output  1  one-cycle timeout pulse.

Function
REQ-016 SHALL implement states IDLE, RUN, DONE, ABORT; all outputs registered.
REQ-017 IDLE: if |req and sort_ready at edge N, then after edge N: gnt=onehot(w), cur_id=w, sort_start=1, sort_en=1, state=RUN, watchdog=0.
REQ-018 Winner w SHALL be the first set req bit searching upward from pointer ptr with wrap mod NREQ; ptr<=(w+1) mod NREQ at grant.
REQ-019 IDLE with req=0 or sort_ready=0 SHALL hold: gnt=0, sort_en=0, sort_start=0.
REQ-020 sort_start SHALL be high for exactly the first RUN cycle only.
REQ-021 RUN: sort_en = !hold; watchdog increments each RUN cycle with hold=0 and freezes while hold=1.
REQ-022 RUN: sort_oe=1 -> DONE; otherwise watchdog==TIMEOUT-1 with hold=0 -> ABORT.
REQ-023 sort_oe and timeout in the same cycle SHALL resolve to DONE.
REQ-024 DONE (one cycle): done[cur_id]=1, gnt held, sort_en=1; next state IDLE with gnt=0.
REQ-025 ABORT (one cycle): err=1, done=0, sort_en=0, gnt held; next state IDLE with gnt=0.
REQ-026 req changes during RUN/DONE/ABORT SHALL be ignored; dropping req[cur_id] SHALL NOT cancel the job, and done still pulses.
REQ-027 Back-to-back jobs SHALL have at least one IDLE cycle between DONE/ABORT and the next grant.
REQ-028 A requester still asserting req after done SHALL be eligible again, at rotated (lower) priority.
REQ-029 sort_oe seen in IDLE SHALL be ignored.

Reset
REQ-030 rst low SHALL asynchronously force state=IDLE, ptr=0, watchdog=0, and gnt, cur_id, done, sort_start, sort_en, busy, err all 0.
REQ-031 Reset mid-job SHALL drop sort_en immediately with no done or err pulse; the sorter is reset separately by the integrator.
REQ-032 After rst releases, the first grant SHALL follow REQ-017 on the first edge with rst high.

Structure
REQ-033 State encodings and NREQ/TIMEOUT defaults SHALL live in shared package mdsa_pkg.
REQ-034 The combinational round-robin search SHALL be sub-module mdsa_rr_pick (inputs req and ptr; outputs w and any).
REQ-035 The watchdog SHALL be 8 bits, unsigned, and never wrap within a job.

Verification
REQ-036 req=4'b0001, sort_ready=1, sort_oe 70 cycles after start -> gnt=0001 and sort_start 1 cycle after req; done[0] pulses once; busy drops the next cycle.
REQ-037 req=4'b1111 held, sorter always completes -> grant order 0,1,2,3,0; ptr wraps 3->0.
REQ-038 sort_oe never asserted -> err pulses after exactly 127 RUN cycles; done=0; then IDLE.
REQ-039 hold=1 for 20 cycles mid-RUN, no sort_oe -> sort_en=0 during hold; err arrives 20 cycles later than in REQ-038.
REQ-040 rst pulled low during RUN -> all outputs 0 asynchronously without waiting for a clock edge; after release, req=0010 is granted with ptr starting at 0.
REQ-041 sort_oe and timeout in the same cycle -> done pulses and err stays 0.

Source files
------------

// File: rtl/mdsa_pkg.sv
// mdsa_pkg
//   Shared definitions for the sort arbiter: controller state encoding,
//   default parameter values and the watchdog width.
//   No ports (package).
package mdsa_pkg;

    localparam int NREQ_DEF    = 4;    // requesters sharing one sorter
    localparam int TIMEOUT_DEF = 127;  // RUN cycles before a job is aborted
    localparam int WD_W        = 8;    // watchdog counter width

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DONE  = 2'd2,
        ST_ABORT = 2'd3
    } state_t;

endpackage

// File: rtl/mdsa_rr_pick.sv
// mdsa_rr_pick
//   Combinational round-robin search: returns the first set request bit
//   found searching upward from ptr, wrapping modulo NREQ.
//   Ports:
//     req [NREQ-1:0]  request vector
//     ptr [2:0]       highest-priority index for this search (< NREQ)
//     w   [2:0]       winning index (0 when nothing is requested)
//     any             at least one request is set
module mdsa_rr_pick
    import mdsa_pkg::*;
#(
    parameter int NREQ = NREQ_DEF
) (
    input  logic [NREQ-1:0] req,
    input  logic [2:0]      ptr,
    output logic [2:0]      w,
    output logic            any
);

    // Offsets are scanned from farthest to nearest so the request closest
    // to ptr overwrites any earlier hit and ends up as the winner.
    always_comb begin
        // NOTE: every combinational output gets a default first so no
        // path through the loops can leave it unassigned (no latch).
        w   = '0;
        any = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            for (int j = 0; j < NREQ; j++) begin
                if (req[j] && ((int'(ptr) + i) % NREQ == j)) begin
                    w   = 3'(j);
                    any = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mdsa_sort_arbiter.sv
// mdsa_sort_arbiter
//   Round-robin arbiter granting one shared sorter to NREQ requesters, with
//   a watchdog that aborts a job after TIMEOUT non-held RUN cycles.
//   Ports:
//     clk         rising-edge clock
//     rst         asynchronous active-low reset
//     req         per-requester level request, held until done
//     hold        pause: freezes sorter enable and watchdog
//     sort_ready  sorter idle/ready
//     sort_oe     sorter output-valid pulse
//     gnt         one-hot grant, held for the whole job
//     cur_id      index of the granted requester
//     done        one-cycle completion pulse to the granted requester
//     sort_start  one-cycle start pulse to the sorter
//     sort_en     sorter enable
//     busy        controller not idle
//     err         one-cycle timeout pulse
module mdsa_sort_arbiter
    import mdsa_pkg::*;
#(
    parameter int NREQ    = NREQ_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            hold,
    input  logic            sort_ready,
    input  logic            sort_oe,
    output logic [NREQ-1:0] gnt,
    output logic [2:0]      cur_id,
    output logic [NREQ-1:0] done,
    output logic            sort_start,
    output logic            sort_en,
    output logic            busy,
    output logic            err
);

    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    state_t          state;
    logic [2:0]      ptr;
    logic [WD_W-1:0] wd;

    logic [2:0]      w;
    logic            any;
    logic [NREQ-1:0] w_onehot;
    logic [2:0]      ptr_next;

    mdsa_rr_pick #(.NREQ(NREQ)) u_pick (
        .req (req),
        .ptr (ptr),
        .w   (w),
        .any (any)
    );

    always_comb begin
        w_onehot = NREQ'(1) << w;
        ptr_next = (int'(w) == NREQ - 1) ? 3'd0 : w + 3'd1;
    end

    // NOTE: all state and outputs live in one clocked block and use
    // non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            ptr        <= '0;
            wd         <= '0;
            gnt        <= '0;
            cur_id     <= '0;
            done       <= '0;
            sort_start <= 1'b0;
            sort_en    <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b0;
        end else begin
            // Pulse outputs default low; only the transitions raise them.
            sort_start <= 1'b0;
            done       <= '0;
            err        <= 1'b0;

            case (state)
                ST_IDLE: begin
                    gnt     <= '0;
                    sort_en <= 1'b0;
                    busy    <= 1'b0;
                    if (any && sort_ready) begin
                        state      <= ST_RUN;
                        gnt        <= w_onehot;
                        cur_id     <= w;
                        ptr        <= ptr_next;
                        wd         <= '0;
                        sort_start <= 1'b1;
                        sort_en    <= 1'b1;
                        busy       <= 1'b1;
                    end
                end

                ST_RUN: begin
                    // A completion always beats a simultaneous timeout.
                    if (sort_oe) begin
                        state   <= ST_DONE;
                        done    <= gnt;
                        sort_en <= 1'b1;
                    end else if (!hold && wd == WD_LAST) begin
                        state   <= ST_ABORT;
                        err     <= 1'b1;
                        sort_en <= 1'b0;
                    end else begin
                        sort_en <= !hold;
                        if (!hold) begin
                            wd <= wd + 1'b1;
                        end
                    end
                end

                ST_DONE, ST_ABORT: begin
                    state   <= ST_IDLE;
                    gnt     <= '0;
                    sort_en <= 1'b0;
                    busy    <= 1'b0;
                end

                default: begin
                    state   <= ST_IDLE;
                    gnt     <= '0;
                    sort_en <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdsa_sort_arbiter.sv
// tb_mdsa_sort_arbiter
//   Directed self-checking bench for mdsa_sort_arbiter (NREQ=4, TIMEOUT=127).
//   Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_mdsa_sort_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       hold;
    logic       sort_ready;
    logic       sort_oe;
    logic [3:0] gnt;
    logic [2:0] cur_id;
    logic [3:0] done;
    logic       sort_start;
    logic       sort_en;
    logic       busy;
    logic       err;

    int checks   = 0;
    int failures = 0;

    mdsa_sort_arbiter #(.NREQ(4), .TIMEOUT(127)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .hold       (hold),
        .sort_ready (sort_ready),
        .sort_oe    (sort_oe),
        .gnt        (gnt),
        .cur_id     (cur_id),
        .done       (done),
        .sort_start (sort_start),
        .sort_en    (sort_en),
        .busy       (busy),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, " gnt"},  32'(gnt), 32'h0);
        check({tag, " busy"}, 32'(busy), 32'h0);
        check({tag, " done"}, 32'(done), 32'h0);
        check({tag, " err"},  32'(err), 32'h0);
        check({tag, " sort_en"}, 32'(sort_en), 32'h0);
    endtask

    initial begin
        int exp_ids [5];
        exp_ids = '{0, 1, 2, 3, 0};

        rst        = 1'b0;
        req        = 4'b0000;
        hold       = 1'b0;
        sort_ready = 1'b0;
        sort_oe    = 1'b0;

        // Reset values.
        #12;
        check("rst gnt",        32'(gnt), 32'h0);
        check("rst cur_id",     32'(cur_id), 32'h0);
        check("rst done",       32'(done), 32'h0);
        check("rst sort_start", 32'(sort_start), 32'h0);
        check("rst sort_en",    32'(sort_en), 32'h0);
        check("rst busy",       32'(busy), 32'h0);
        check("rst err",        32'(err), 32'h0);
        #10 rst = 1'b1;

        // IDLE holds with no request, and with a request but sorter not ready.
        tick(1);
        check_idle("idle noreq");
        req = 4'b0001;
        tick(1);
        check_idle("idle notready");

        // Single job: grant one cycle after request, done after 70 cycles.
        sort_ready = 1'b1;
        tick(1);
        check("job0 gnt",        32'(gnt), 32'h1);
        check("job0 cur_id",     32'(cur_id), 32'h0);
        check("job0 sort_start", 32'(sort_start), 32'h1);
        check("job0 sort_en",    32'(sort_en), 32'h1);
        check("job0 busy",       32'(busy), 32'h1);
        tick(1);
        check("job0 start drop", 32'(sort_start), 32'h0);
        check("job0 en run",     32'(sort_en), 32'h1);
        tick(67);
        sort_oe = 1'b1;
        tick(1);
        sort_oe = 1'b0;
        req     = 4'b0000;
        check("job0 done",       32'(done), 32'h1);
        check("job0 done gnt",   32'(gnt), 32'h1);
        check("job0 done en",    32'(sort_en), 32'h1);
        check("job0 done busy",  32'(busy), 32'h1);
        tick(1);
        check_idle("job0 after");

        // Round robin from a fresh pointer: order 0,1,2,3,0.
        rst = 1'b0;
        #4 rst = 1'b1;
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick(1);
            check($sformatf("rr%0d cur_id", k), 32'(cur_id), 32'(exp_ids[k]));
            check($sformatf("rr%0d gnt", k), 32'(gnt), 32'(4'b0001 << exp_ids[k]));
            sort_oe = 1'b1;
            tick(1);
            sort_oe = 1'b0;
            check($sformatf("rr%0d done", k), 32'(done), 32'(4'b0001 << exp_ids[k]));
            tick(1);
            check($sformatf("rr%0d gap gnt", k), 32'(gnt), 32'h0);
        end
        req = 4'b0000;
        tick(1);

        // Timeout: pointer is 1, only req[2] -> grant 2; req changes ignored.
        req = 4'b0100;
        tick(1);
        check("to cur_id", 32'(cur_id), 32'h2);
        req = 4'b0001;
        tick(126);
        check("to pre err",  32'(err), 32'h0);
        check("to pre gnt",  32'(gnt), 32'h4);
        check("to pre busy", 32'(busy), 32'h1);
        tick(1);
        req = 4'b0000;
        check("to err",     32'(err), 32'h1);
        check("to done",    32'(done), 32'h0);
        check("to sort_en", 32'(sort_en), 32'h0);
        check("to gnt",     32'(gnt), 32'h4);
        tick(1);
        check_idle("to after");

        // Hold for 20 cycles delays the timeout by 20 cycles.
        req = 4'b0001;
        tick(1);
        check("hold cur_id", 32'(cur_id), 32'h0);
        tick(10);
        hold = 1'b1;
        tick(1);
        check("hold en first", 32'(sort_en), 32'h0);
        tick(19);
        check("hold en last", 32'(sort_en), 32'h0);
        hold = 1'b0;
        tick(1);
        check("hold en back", 32'(sort_en), 32'h1);
        tick(115);
        check("hold pre err", 32'(err), 32'h0);
        tick(1);
        req = 4'b0000;
        check("hold err", 32'(err), 32'h1);
        tick(1);
        check_idle("hold after");

        // sort_oe on the timeout cycle resolves to DONE.
        req = 4'b0010;
        tick(1);
        check("tie cur_id", 32'(cur_id), 32'h1);
        tick(126);
        sort_oe = 1'b1;
        tick(1);
        sort_oe = 1'b0;
        req     = 4'b0000;
        check("tie done", 32'(done), 32'h2);
        check("tie err",  32'(err), 32'h0);
        tick(1);
        check("tie after err", 32'(err), 32'h0);

        // sort_oe while idle is ignored.
        sort_oe = 1'b1;
        tick(1);
        sort_oe = 1'b0;
        check_idle("idle oe");

        // Asynchronous reset mid-job, then grant right after release.
        req = 4'b0001;
        tick(1);
        check("ar busy before", 32'(busy), 32'h1);
        tick(3);
        #2 rst = 1'b0;
        #1;
        check("ar gnt",        32'(gnt), 32'h0);
        check("ar cur_id",     32'(cur_id), 32'h0);
        check("ar sort_en",    32'(sort_en), 32'h0);
        check("ar sort_start", 32'(sort_start), 32'h0);
        check("ar busy",       32'(busy), 32'h0);
        check("ar done",       32'(done), 32'h0);
        check("ar err",        32'(err), 32'h0);
        req = 4'b0010;
        #1 rst = 1'b1;
        tick(1);
        check("ar regrant gnt",   32'(gnt), 32'h2);
        check("ar regrant id",    32'(cur_id), 32'h1);
        check("ar regrant start", 32'(sort_start), 32'h1);
        sort_oe = 1'b1;
        tick(1);
        sort_oe = 1'b0;
        req     = 4'b0000;
        check("ar done", 32'(done), 32'h2);
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
